// File: rtl/vga_fb_arbiter_if.sv
// Host write handshake and single-port frame-buffer RAM bus for vga_fb_arbiter.
// The master modport is the arbiter; the slave modport is the host/RAM side.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              wr_ack;
  logic              wr_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [23:0]       mem_wdata;
  logic [23:0]       mem_rdata;

  modport master (
    input  wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, wr_err, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, wr_err, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: scaled scan-out reads own the RAM during visible
// pixels, host writes fill the remaining cycles with a one-cycle ack.
module vga_fb_arbiter #(
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 300,
  parameter int H_SCALE  = 5,
  parameter int V_SCALE  = 2,
  parameter int ADDR_W   = 16,
  parameter int FB_DEPTH = 48000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   h_active,
  input  logic                   v_active,
  input  logic                   frame_start,
  vga_fb_arbiter_if.master       bus,
  output logic [23:0]            pixel,
  output logic                   pixel_valid
);

  localparam int COL_W = (IMG_W   > 1) ? $clog2(IMG_W)   : 1;
  localparam int HS_W  = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;
  localparam int VS_W  = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [HS_W-1:0]   HS_LAST   = HS_W'(H_SCALE - 1);
  localparam logic [VS_W-1:0]   VS_LAST   = VS_W'(V_SCALE - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'((IMG_H - 1) * IMG_W);

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    SCAN      = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [COL_W-1:0]  col_reg, col_next, col_cur;
  logic [HS_W-1:0]   h_sub_reg, h_sub_next, h_sub_cur;
  logic [VS_W-1:0]   v_sub_reg, v_sub_next, v_sub_cur;
  logic [ADDR_W-1:0] line_base_reg, line_base_next, line_base_cur;

  logic        h_active_d_reg;
  logic        pixel_valid_reg;
  logic        ack_reg;
  logic        err_reg;
  logic [23:0] wdata_hold_reg;

  logic disp_rd;
  logic line_end;
  logic wr_accept;
  logic wr_in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= SYNC_WAIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // rst also gates the combinational port so every output is 0 while it is held
  always_comb begin
    state_next = state_reg;
    if (frame_start) begin
      state_next = SCAN;
    end
    disp_rd = ~rst & h_active & v_active & ((state_reg == SCAN) | frame_start);
  end

  // frame_start coincides with the first visible pixel, so it zeroes the
  // counters used for that very cycle's address, not just the next one
  always_comb begin
    col_cur       = frame_start ? '0 : col_reg;
    h_sub_cur     = frame_start ? '0 : h_sub_reg;
    v_sub_cur     = frame_start ? '0 : v_sub_reg;
    line_base_cur = frame_start ? '0 : line_base_reg;

    col_next       = col_cur;
    h_sub_next     = h_sub_cur;
    v_sub_next     = v_sub_cur;
    line_base_next = line_base_cur;

    line_end = h_active_d_reg & ~h_active & v_active;

    if (disp_rd) begin
      if (h_sub_cur == HS_LAST) begin
        h_sub_next = '0;
        if (col_cur != COL_LAST) begin
          col_next = col_cur + 1'b1;
        end
      end else begin
        h_sub_next = h_sub_cur + 1'b1;
      end
    end else if (line_end) begin
      col_next   = '0;
      h_sub_next = '0;
      if (v_sub_cur == VS_LAST) begin
        v_sub_next = '0;
        if (line_base_cur != LINE_LAST) begin
          line_base_next = line_base_cur + LINE_STEP;
        end
      end else begin
        v_sub_next = v_sub_cur + 1'b1;
      end
    end
  end

  // ack_reg blocks the cycle after an accept so a held request is taken once
  always_comb begin
    wr_in_range   = (32'(bus.wr_addr) < 32'(FB_DEPTH));
    wr_accept     = ~rst & bus.wr_req & ~disp_rd & ~ack_reg;
    bus.mem_we    = wr_accept & wr_in_range;
    bus.mem_addr  = '0;
    if (disp_rd) begin
      bus.mem_addr = line_base_cur + ADDR_W'(col_cur);
    end else if (bus.mem_we) begin
      bus.mem_addr = bus.wr_addr;
    end
    bus.mem_wdata = bus.mem_we ? bus.wr_data : wdata_hold_reg;
    bus.wr_ack    = ack_reg;
    bus.wr_err    = err_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_reg         <= '0;
      h_sub_reg       <= '0;
      v_sub_reg       <= '0;
      line_base_reg   <= '0;
      h_active_d_reg  <= 1'b0;
      pixel_valid_reg <= 1'b0;
      ack_reg         <= 1'b0;
      err_reg         <= 1'b0;
      wdata_hold_reg  <= '0;
    end else begin
      col_reg         <= col_next;
      h_sub_reg       <= h_sub_next;
      v_sub_reg       <= v_sub_next;
      line_base_reg   <= line_base_next;
      h_active_d_reg  <= h_active;
      pixel_valid_reg <= disp_rd;
      ack_reg         <= wr_accept;
      err_reg         <= wr_accept & ~wr_in_range;
      if (bus.mem_we) begin
        wdata_hold_reg <= bus.wr_data;
      end
    end
  end

  // RAM output register supplies the pixel aligned with pixel_valid
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign pixel[gi*8 +: 8] = pixel_valid_reg ? bus.mem_rdata[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  assign pixel_valid = pixel_valid_reg;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: RAM model, pixel and write scoreboards,
// immediate assertions at each comparison point.
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s: observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

module tb_vga_fb_arbiter;

  localparam int IMG_W    = 160;
  localparam int IMG_H    = 300;
  localparam int H_SCALE  = 5;
  localparam int V_SCALE  = 2;
  localparam int ADDR_W   = 16;
  localparam int FB_DEPTH = 48000;

  typedef struct {
    int          addr;
    logic [23:0] data;
  } pix_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [23:0]       data;
    logic              err;
    logic              written;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        h_active, v_active, frame_start;
  logic [23:0] pixel;
  logic        pixel_valid;
  logic        preload;

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  vga_fb_arbiter #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .H_SCALE(H_SCALE), .V_SCALE(V_SCALE),
    .ADDR_W(ADDR_W), .FB_DEPTH(FB_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .h_active(h_active), .v_active(v_active),
    .frame_start(frame_start), .bus(bus), .pixel(pixel), .pixel_valid(pixel_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pat(input int a);
    logic [31:0] u;
    u = a;
    return {u[7:0] ^ 8'h3C, u[15:8], u[7:0] + 8'h11};
  endfunction

  function automatic int exp_addr(input int ln, input int px);
    int r;
    int c;
    r = ln / V_SCALE;
    c = px / H_SCALE;
    if (r > IMG_H - 1) r = IMG_H - 1;
    if (c > IMG_W - 1) c = IMG_W - 1;
    return r * IMG_W + c;
  endfunction

  // Synchronous-read RAM model
  logic [23:0] ram [0:FB_DEPTH-1];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < FB_DEPTH; i++) ram[i] <= pat(i);
    end else if (bus.mem_we && int'(bus.mem_addr) < FB_DEPTH) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= (int'(bus.mem_addr) < FB_DEPTH) ? ram[bus.mem_addr] : 24'h0;
  end

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        scan_on = 1'b0;
  int          line = 0;
  int          pix = 0;
  logic        h_prev = 1'b0;
  logic        exp_valid_d = 1'b0;
  logic        ack_seen = 1'b0;
  pix_t        pix_q[$];
  wr_t         wr_q[$];
  wr_t         host_q[$];
  logic [23:0] exp_mem [int];
  int          we_cyc = -1, we_first = -1, ack_cyc = -1, fall_cyc = -1;
  int          n_pv = 0, n_acks = 0, n_errs = 0, n_writes = 0, max_rd = 0;
  logic [23:0] last_pix100 = 24'h0;

  task automatic host_push(input int a, input logic [23:0] d);
    wr_t w;
    w.addr    = ADDR_W'(a);
    w.data    = d;
    w.err     = (a >= FB_DEPTH);
    w.written = 1'b0;
    host_q.push_back(w);
  endtask

  task automatic step(input logic h, input logic v, input logic fs);
    logic rd_exp;
    int   ea;
    pix_t pe;
    wr_t  w;
    @(posedge clk);
    #1;
    cyc++;
    if (ack_seen) begin
      bus.wr_req = 1'b0;
      ack_seen   = 1'b0;
    end
    if (!bus.wr_req && host_q.size() > 0) begin
      w = host_q.pop_front();
      bus.wr_req  = 1'b1;
      bus.wr_addr = w.addr;
      bus.wr_data = w.data;
      wr_q.push_back(w);
    end
    h_active    = h;
    v_active    = v;
    frame_start = fs;
    if (fs) begin
      scan_on = 1'b1;
      line    = 0;
      pix     = 0;
    end
    rd_exp = scan_on && h && v;
    if (h_prev && !h) fall_cyc = cyc;
    @(negedge clk);

    if (bus.mem_we) begin
      `CHK("spurious_we", wr_q.size() > 0, 1'b1)
      if (wr_q.size() > 0) begin
        `CHK("we_addr", bus.mem_addr, wr_q[0].addr)
        `CHK("we_data", bus.mem_wdata, wr_q[0].data)
        `CHK("we_in_range", wr_q[0].err, 1'b0)
        `CHK("we_once", wr_q[0].written, 1'b0)
        w = wr_q[0];
        w.written = 1'b1;
        wr_q[0] = w;
        exp_mem[int'(w.addr)] = w.data;
      end
      n_writes++;
      we_cyc = cyc;
      if (we_first < 0) we_first = cyc;
    end

    if (bus.wr_ack) begin
      `CHK("spurious_ack", wr_q.size() > 0, 1'b1)
      if (wr_q.size() > 0) begin
        w = wr_q.pop_front();
        `CHK("ack_err", bus.wr_err, w.err)
        if (!w.err) `CHK("ack_after_we", w.written, 1'b1)
      end
      n_acks++;
      if (bus.wr_err) n_errs++;
      ack_cyc  = cyc;
      ack_seen = 1'b1;
    end else begin
      `CHK("err_idle", bus.wr_err, 1'b0)
    end

    if (rd_exp) begin
      ea = exp_addr(line, pix);
      `CHK("rd_we", bus.mem_we, 1'b0)
      `CHK("rd_addr", int'(bus.mem_addr), ea)
      if (int'(bus.mem_addr) > max_rd) max_rd = int'(bus.mem_addr);
      pe.addr = ea;
      pe.data = exp_mem.exists(ea) ? exp_mem[ea] : pat(ea);
      pix_q.push_back(pe);
      pix++;
    end

    `CHK("pix_valid", pixel_valid, exp_valid_d)
    if (pixel_valid) n_pv++;
    if (exp_valid_d) begin
      pe = pix_q.pop_front();
      `CHK("pixel", pixel, pe.data)
      if (pe.addr == 100) last_pix100 = pixel;
    end else begin
      `CHK("pixel_blank", pixel, 24'h0)
    end
    exp_valid_d = rd_exp;

    if (h_prev && !h && v) begin
      line++;
      pix = 0;
    end
    h_prev = h;
  endtask

  task automatic run_line(input int act, input int blank, input logic fs);
    for (int i = 0; i < act; i++) step(1'b1, 1'b1, fs && (i == 0));
    for (int i = 0; i < blank; i++) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_outputs_zero(input int k);
    `CHK("rst_mem_we", bus.mem_we, 1'b0)
    `CHK("rst_mem_addr", bus.mem_addr, 16'h0)
    `CHK("rst_mem_wdata", bus.mem_wdata, 24'h0)
    `CHK("rst_wr_ack", bus.wr_ack, 1'b0)
    `CHK("rst_wr_err", bus.wr_err, 1'b0)
    `CHK("rst_pixel", pixel, 24'h0)
    `CHK("rst_pixel_valid", pixel_valid, 1'b0)
    $display("reset check %0d at cycle %0d done", k, cyc);
  endtask

  initial begin
    int w0, a0, e0;
    rst = 1'b1; preload = 1'b1;
    h_active = 1'b0; v_active = 1'b0; frame_start = 1'b0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    @(posedge clk); #1; preload = 1'b0;
    @(posedge clk); @(negedge clk);
    check_outputs_zero(0);
    @(posedge clk); #1; rst = 1'b0;

    // Back-to-back writes while waiting for sync; window flags alone must not read
    for (int i = 0; i < 10; i++) host_push(i, 24'hC00000 + 24'(i));
    w0 = n_writes; a0 = n_acks; e0 = n_errs; we_first = -1;
    for (int i = 0; i < 25; i++) step(1'b1, 1'b1, 1'b0);
    `CHK("b2b_writes", n_writes - w0, 10)
    `CHK("b2b_acks", n_acks - a0, 10)
    `CHK("b2b_errs", n_errs - e0, 0)
    `CHK("b2b_span", we_cyc - we_first, 18)
    `CHK("sync_no_reads", n_pv, 0)
    $display("sync-wait writes: %0d writes, %0d acks", n_writes - w0, n_acks - a0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);

    // Line 0 with a write held across the visible region
    host_push(100, 24'hFF0000);
    n_pv = 0;
    run_line(800, 256, 1'b1);
    `CHK("line0_pv_count", n_pv, 800)
    `CHK("wr_first_blank", we_cyc, fall_cyc)
    `CHK("wr_ack_latency", ack_cyc, fall_cyc + 1)
    $display("line 0: pv=%0d write@%0d ack@%0d", n_pv, we_cyc, ack_cyc);

    // Line 1 with an out-of-range write
    host_push(48000, 24'h123456);
    w0 = n_writes; e0 = n_errs;
    run_line(800, 256, 1'b0);
    `CHK("oor_err_ack", n_errs - e0, 1)
    `CHK("oor_no_write", n_writes - w0, 0)
    `CHK("pix100_stored", last_pix100, 24'hFF0000)
    $display("line 1: oor errs=%0d pixel100=%h", n_errs - e0, last_pix100);

    run_line(800, 256, 1'b0);
    run_line(800, 256, 1'b0);
    for (int i = 4; i < 599; i++) run_line(1, 1, 1'b0);
    n_pv = 0;
    run_line(800, 256, 1'b0);
    `CHK("line599_pv_count", n_pv, 800)
    `CHK("max_read_addr", max_rd, 47999)
    $display("line 599: pv=%0d max addr=%0d", n_pv, max_rd);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);

    // Reset mid-line with a stalled write
    host_push(7, 24'h00ABCD);
    a0 = n_acks;
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 49; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cyc++;
      rst = 1'b1;
      if (i == 1) bus.wr_req = 1'b0;
      @(negedge clk);
      check_outputs_zero(i + 1);
    end
    wr_q.delete(); host_q.delete(); pix_q.delete();
    exp_valid_d = 1'b0; scan_on = 1'b0; ack_seen = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    n_pv = 0;
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
    `CHK("rst_no_reads", n_pv, 0)
    `CHK("rst_no_ack", n_acks, a0)
    run_line(800, 256, 1'b1);
    `CHK("restart_pv_count", n_pv, 800)
    $display("after reset: pv=%0d acks=%0d", n_pv, n_acks - a0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
